// File: rtl/crc16_frame_seq.sv
// Frame sequencer for the 8-bit parallel CRC-16 engine: clears the engine, passes payload through and appends the CRC (MSB first).
// Optional build macro CRC_XOROUT_EN: when defined, the captured CRC is XORed with XOROUT.
module crc16_frame_seq #(
  parameter int          ENG_LAT = 2,
  parameter int          MAX_LEN = 1024,
  parameter int          LEN_W   = 11,
  parameter logic [15:0] XOROUT  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        eng_rst_n,
  output logic [7:0]  eng_data,
  output logic        eng_data_valid,
  input  logic [15:0] eng_crc,
  output logic        busy,
  output logic        frame_trunc,
  output logic [2:0]  dbg_state
);

  // Handshake: a byte moves on s_* or m_* exactly on a cycle where valid and ready are
  // both high at the rising edge; while m_valid=1 and m_ready=0 the m_* outputs hold.

  localparam int LAT_W = (ENG_LAT > 1) ? $clog2(ENG_LAT) : 1;

`ifdef CRC_XOROUT_EN
  localparam logic XOR_EN = 1'b1;
`else
  localparam logic XOR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    DATA   = 3'd2,
    DRAIN  = 3'd3,
    APP_HI = 3'd4,
    APP_LO = 3'd5
  } state_t;

  state_t           state_q;
  logic [15:0]      crc_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LAT_W-1:0] lat_q;
  logic             trunc_q;

  logic             accept;
  logic             at_max;
  logic [15:0]      crc_cap;

  assign accept  = (state_q == DATA) && s_valid && m_ready;
  assign at_max  = (cnt_q == LEN_W'(MAX_LEN - 1));
  assign crc_cap = eng_crc ^ (XOROUT & {16{XOR_EN}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      crc_q   <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      trunc_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_valid) state_q <= CLR;
        end
        CLR: begin
          state_q <= DATA;
        end
        DATA: begin
          if (accept) begin
            cnt_q <= cnt_q + 1'b1;
            // s_last on the final allowed byte is a normal end, not a truncation
            if (s_last || at_max) begin
              state_q <= DRAIN;
              lat_q   <= '0;
              trunc_q <= at_max && !s_last;
            end
          end
        end
        DRAIN: begin
          if (lat_q == LAT_W'(ENG_LAT - 1)) begin
            crc_q   <= crc_cap;
            state_q <= APP_HI;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        APP_HI: begin
          if (m_ready) state_q <= APP_LO;
        end
        APP_LO: begin
          if (m_ready) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready        = 1'b0;
    m_data         = 8'h00;
    m_valid        = 1'b0;
    m_last         = 1'b0;
    eng_data_valid = 1'b0;
    case (state_q)
      DATA: begin
        s_ready        = m_ready;
        m_data         = s_data;
        m_valid        = s_valid;
        eng_data_valid = s_valid && m_ready;
      end
      APP_HI: begin
        m_data  = crc_q[15:8];
        m_valid = 1'b1;
      end
      APP_LO: begin
        m_data  = crc_q[7:0];
        m_valid = 1'b1;
        m_last  = 1'b1;
      end
      default: ;
    endcase
  end

  // The engine is held clear through system reset as well as the CLR cycle
  assign eng_rst_n   = rst_n && (state_q != CLR);
  assign eng_data    = s_data;
  assign busy        = (state_q != IDLE);
  assign frame_trunc = trunc_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_crc16_frame_seq.sv
// Directed bench for crc16_frame_seq with a two-stage engine stub (MAX_LEN=4).
// Build with CRC_XOROUT_EN defined to check the XOR-out variant.
module tb_crc16_frame_seq;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b1;
  logic        eng_rst_n;
  logic [7:0]  eng_data;
  logic        eng_data_valid;
  logic [15:0] eng_crc = 16'h0000;
  logic        busy;
  logic        frame_trunc;
  logic [2:0]  dbg_state;

  logic [15:0] stub_t = 16'h0000;
  bit          toggle_mode = 1'b0;
  logic [15:0] crc_exp;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  int         ev_q[$];
  int cyc = 0, clr_cyc = 0, clr_cnt = 0, trunc_cnt = 0, trunc_cyc = 0, busy_cnt = 0;
  int sready_err = 0, stab_err = 0, stall_cnt = 0, ev_bad = 0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_m = 9'h000;

  crc16_frame_seq #(.ENG_LAT(2), .MAX_LEN(4), .LEN_W(3), .XOROUT(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .eng_rst_n(eng_rst_n), .eng_data(eng_data), .eng_data_valid(eng_data_valid),
    .eng_crc(eng_crc), .busy(busy), .frame_trunc(frame_trunc), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog");
  end

  // Engine stub: result is A5C3 exactly ENG_LAT cycles after a strobe, DEAD otherwise
  always @(posedge clk) begin
    if (!eng_rst_n) begin
      stub_t  <= 16'h0000;
      eng_crc <= 16'h0000;
    end else begin
      stub_t  <= eng_data_valid ? 16'hA5C3 : 16'hDEAD;
      eng_crc <= stub_t;
    end
  end

  // Downstream ready: steady 1, or toggling every cycle
  always @(posedge clk) begin
    #1;
    m_ready <= toggle_mode ? ~m_ready : 1'b1;
  end

  // Monitor (samples on the falling edge)
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (m_valid && m_ready) obs_q.push_back({m_last, m_data});
    if (eng_data_valid) ev_q.push_back(cyc);
    if (eng_data_valid && dbg_state != ST_DATA) ev_bad <= ev_bad + 1;
    if (rst_n && !eng_rst_n) begin
      clr_cyc <= cyc;
      clr_cnt <= clr_cnt + 1;
    end
    if (frame_trunc) begin
      trunc_cnt <= trunc_cnt + 1;
      trunc_cyc <= cyc;
    end
    if (busy) busy_cnt <= busy_cnt + 1;
    if (!m_ready && s_ready) sready_err <= sready_err + 1;
    if (prev_stall && (!m_valid || {m_last, m_data} != prev_m)) stab_err <= stab_err + 1;
    if (m_valid && !m_ready) stall_cnt <= stall_cnt + 1;
    prev_stall <= m_valid && !m_ready;
    prev_m     <= {m_last, m_data};
  end

  // Driver tasks
  task automatic put_byte(input logic [7:0] d, input logic last);
    int k;
    k = 0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    do begin
      @(negedge clk);
      k++;
    end while (!s_ready && k < 400);
    if (!s_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL put_byte_timeout: byte %h not accepted after %0d cycles, expected acceptance", d, k);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_obs(input int target, input string tag);
    int k;
    k = 0;
    while (obs_q.size() < target && k < 400) begin
      @(posedge clk);
      k++;
    end
    if (obs_q.size() < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d output bytes, expected %0d", tag, obs_q.size(), target);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic add_exp(input logic [7:0] d);
    exp_q.push_back({1'b0, d});
  endtask

  task automatic add_crc();
    exp_q.push_back({1'b0, crc_exp[15:8]});
    exp_q.push_back({1'b1, crc_exp[7:0]});
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (eng_rst_n !== 1'b0) begin
      n_err++;
      $display("FAIL reset_eng_rst_n: got %b, expected 0", eng_rst_n);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({m_valid, m_last, s_ready, busy, frame_trunc} !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, expected 00000", {m_valid, m_last, s_ready, busy, frame_trunc});
    end
    n_cmp++;
    if (dbg_state !== ST_IDLE || eng_rst_n !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: got state %0d eng_rst_n %b, expected 0 1", dbg_state, eng_rst_n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int ob, eb, cb;
    ob = obs_q.size(); eb = ev_q.size(); cb = clr_cnt;
    exp_q.delete();
    add_exp(8'h01); add_exp(8'h02); add_exp(8'h03); add_crc();
    put_byte(8'h01, 1'b0); put_byte(8'h02, 1'b0); put_byte(8'h03, 1'b1);
    wait_obs(ob + exp_q.size(), "basic");
    n_cmp++;
    if (obs_q.size() - ob != exp_q.size()) begin
      n_err++;
      $display("FAIL basic_count: got %0d bytes, expected %0d", obs_q.size() - ob, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (((ob + i) < obs_q.size() ? obs_q[ob + i] : 9'h000) !== exp_q[i]) begin
        n_err++;
        $display("FAIL basic_byte%0d: got %h, expected %h", i, (ob + i) < obs_q.size() ? obs_q[ob + i] : 9'h000, exp_q[i]);
      end
    end
    n_cmp++;
    if (clr_cnt - cb != 1) begin
      n_err++;
      $display("FAIL basic_clr_cycles: got %0d, expected 1", clr_cnt - cb);
    end
    n_cmp++;
    if (ev_q.size() - eb != 3) begin
      n_err++;
      $display("FAIL basic_eng_strobes: got %0d, expected 3", ev_q.size() - eb);
    end
    n_cmp++;
    if (((eb < ev_q.size()) ? ev_q[eb] : -1) != clr_cyc + 1) begin
      n_err++;
      $display("FAIL basic_clr_to_first: got cycle %0d, expected %0d", (eb < ev_q.size()) ? ev_q[eb] : -1, clr_cyc + 1);
    end
  endtask

  task automatic test_backpressure();
    int ob, se, st, sc;
    ob = obs_q.size(); se = sready_err; st = stab_err; sc = stall_cnt;
    exp_q.delete();
    add_exp(8'h01); add_exp(8'h02); add_exp(8'h03); add_crc();
    toggle_mode = 1'b1;
    put_byte(8'h01, 1'b0); put_byte(8'h02, 1'b0); put_byte(8'h03, 1'b1);
    wait_obs(ob + exp_q.size(), "bp");
    toggle_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() - ob != exp_q.size()) begin
      n_err++;
      $display("FAIL bp_count: got %0d bytes, expected %0d", obs_q.size() - ob, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (((ob + i) < obs_q.size() ? obs_q[ob + i] : 9'h000) !== exp_q[i]) begin
        n_err++;
        $display("FAIL bp_byte%0d: got %h, expected %h", i, (ob + i) < obs_q.size() ? obs_q[ob + i] : 9'h000, exp_q[i]);
      end
    end
    n_cmp++;
    if (sready_err - se != 0) begin
      n_err++;
      $display("FAIL bp_s_ready: got %0d cycles with s_ready=1 while m_ready=0, expected 0", sready_err - se);
    end
    n_cmp++;
    if (stab_err - st != 0 || stall_cnt - sc == 0) begin
      n_err++;
      $display("FAIL bp_stable: got %0d unstable of %0d stalls, expected 0 of >0", stab_err - st, stall_cnt - sc);
    end
  endtask

  task automatic test_one_byte();
    int ob, bb;
    ob = obs_q.size(); bb = busy_cnt;
    exp_q.delete();
    add_exp(8'h7E); add_crc();
    put_byte(8'h7E, 1'b1);
    wait_obs(ob + exp_q.size(), "one");
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (((ob + i) < obs_q.size() ? obs_q[ob + i] : 9'h000) !== exp_q[i]) begin
        n_err++;
        $display("FAIL one_byte%0d: got %h, expected %h", i, (ob + i) < obs_q.size() ? obs_q[ob + i] : 9'h000, exp_q[i]);
      end
    end
    n_cmp++;
    if (busy_cnt - bb != 6) begin
      n_err++;
      $display("FAIL one_busy_cycles: got %0d, expected 6", busy_cnt - bb);
    end
  endtask

  task automatic test_truncate();
    int ob, eb, tb0, cb;
    ob = obs_q.size(); eb = ev_q.size(); tb0 = trunc_cnt; cb = clr_cnt;
    exp_q.delete();
    add_exp(8'hB1); add_exp(8'hB2); add_exp(8'hB3); add_exp(8'hB4); add_crc();
    add_exp(8'hB5); add_exp(8'hB6); add_crc();
    put_byte(8'hB1, 1'b0); put_byte(8'hB2, 1'b0); put_byte(8'hB3, 1'b0);
    put_byte(8'hB4, 1'b0); put_byte(8'hB5, 1'b0); put_byte(8'hB6, 1'b1);
    wait_obs(ob + exp_q.size(), "trunc");
    n_cmp++;
    if (obs_q.size() - ob != exp_q.size()) begin
      n_err++;
      $display("FAIL trunc_count: got %0d bytes, expected %0d", obs_q.size() - ob, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (((ob + i) < obs_q.size() ? obs_q[ob + i] : 9'h000) !== exp_q[i]) begin
        n_err++;
        $display("FAIL trunc_byte%0d: got %h, expected %h", i, (ob + i) < obs_q.size() ? obs_q[ob + i] : 9'h000, exp_q[i]);
      end
    end
    n_cmp++;
    if (trunc_cnt - tb0 != 1) begin
      n_err++;
      $display("FAIL trunc_pulses: got %0d, expected 1", trunc_cnt - tb0);
    end
    n_cmp++;
    if (((eb + 3) < ev_q.size() ? ev_q[eb + 3] + 1 : -1) != trunc_cyc) begin
      n_err++;
      $display("FAIL trunc_timing: got cycle %0d, expected %0d", trunc_cyc, (eb + 3) < ev_q.size() ? ev_q[eb + 3] + 1 : -1);
    end
    n_cmp++;
    if (clr_cnt - cb != 2) begin
      n_err++;
      $display("FAIL trunc_frames: got %0d engine clears, expected 2", clr_cnt - cb);
    end
    // s_last on the MAX_LEN-th byte is a normal end
    ob = obs_q.size(); tb0 = trunc_cnt;
    exp_q.delete();
    add_exp(8'hC1); add_exp(8'hC2); add_exp(8'hC3); add_exp(8'hC4); add_crc();
    put_byte(8'hC1, 1'b0); put_byte(8'hC2, 1'b0); put_byte(8'hC3, 1'b0); put_byte(8'hC4, 1'b1);
    wait_obs(ob + exp_q.size(), "maxlast");
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (((ob + i) < obs_q.size() ? obs_q[ob + i] : 9'h000) !== exp_q[i]) begin
        n_err++;
        $display("FAIL maxlast_byte%0d: got %h, expected %h", i, (ob + i) < obs_q.size() ? obs_q[ob + i] : 9'h000, exp_q[i]);
      end
    end
    n_cmp++;
    if (trunc_cnt - tb0 != 0) begin
      n_err++;
      $display("FAIL maxlast_trunc: got %0d pulses, expected 0", trunc_cnt - tb0);
    end
  endtask

  task automatic test_reset_in_drain();
    int ob;
    ob = obs_q.size();
    put_byte(8'h01, 1'b0);
    put_byte(8'h02, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (eng_rst_n !== 1'b0 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drainrst_during: got eng_rst_n %b m_valid %b, expected 0 0", eng_rst_n, m_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== ST_IDLE || m_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL drainrst_after: got state %0d m_valid %b busy %b, expected 0 0 0", dbg_state, m_valid, busy);
    end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() - ob != 2) begin
      n_err++;
      $display("FAIL drainrst_no_crc: got %0d bytes, expected 2", obs_q.size() - ob);
    end
    ob = obs_q.size();
    exp_q.delete();
    add_exp(8'h11); add_crc();
    put_byte(8'h11, 1'b1);
    wait_obs(ob + exp_q.size(), "drainrst_next");
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (((ob + i) < obs_q.size() ? obs_q[ob + i] : 9'h000) !== exp_q[i]) begin
        n_err++;
        $display("FAIL drainrst_next_byte%0d: got %h, expected %h", i, (ob + i) < obs_q.size() ? obs_q[ob + i] : 9'h000, exp_q[i]);
      end
    end
  endtask

  task automatic test_xorout();
    int ob;
    ob = obs_q.size();
    exp_q.delete();
    add_exp(8'h01); add_crc();
    put_byte(8'h01, 1'b1);
    wait_obs(ob + exp_q.size(), "xorout");
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (((ob + i) < obs_q.size() ? obs_q[ob + i] : 9'h000) !== exp_q[i]) begin
        n_err++;
        $display("FAIL xorout_byte%0d: got %h, expected %h", i, (ob + i) < obs_q.size() ? obs_q[ob + i] : 9'h000, exp_q[i]);
      end
    end
    n_cmp++;
    if (ev_bad != 0) begin
      n_err++;
      $display("FAIL eng_valid_outside_data: got %0d strobes, expected 0", ev_bad);
    end
  endtask

  initial begin
`ifdef CRC_XOROUT_EN
    crc_exp = 16'h5A3C;
`else
    crc_exp = 16'hA5C3;
`endif
    test_reset();
    test_basic();
    test_backpressure();
    test_one_byte();
    test_truncate();
    test_reset_in_drain();
    test_xorout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
